maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage.
- Consumes the raster-order 16-bit pixel stream produced by the activation stage and emits one pooled pixel per 2x2 window to the next conv/FC stage.
- Valid/ready handshake on both sides; a one-row half-width line buffer holds the first row of each window pair.

Parameters:
- DATA_W, 16, pixel width (signed two's complement fixed point).
- IMG_W, 28, input columns per row; must be even, >= 2.
- IMG_H, 28, input rows per frame; must be even, >= 2.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_pix  input  DATA_W  input pixel, raster order.
- in_valid  input  1  in_pix valid.
- in_ready  output  1  block accepts in_pix this cycle.
- out_pix  output  DATA_W  pooled pixel.
- out_valid  output  1  out_pix valid.
- out_ready  input  1  downstream accepts out_pix.
- frame_done  output  1  one-cycle pulse when the last pooled pixel of a frame is accepted downstream.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: out_pix=0, out_valid=0, frame_done=0, col=0, row=0, pair register=0. Line buffer contents are don't-care after reset.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready. Input stalls only when the output register is full and not draining. in_ready carries no combinational dependence on in_valid.
- Counters: col 0..IMG_W-1, row 0..IMG_H-1; both advance on input transfer only.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - row wraps to 0 after the last pixel of the frame; no idle gap is needed between frames.
- Even col: pair register <= in_pix.
- Odd col: h = signed max(pair register, in_pix).
  - Even row: linebuf[col>>1] <= h.
  - Odd row: out_pix <= signed max(linebuf[col>>1], h); out_valid <= 1 on the next edge.
- Latency: out_valid rises exactly 1 cycle after the transfer of the window's bottom-right pixel.
- Output register: out_valid clears on output transfer unless a new result loads in the same cycle. Simultaneous drain and load is allowed, giving back-to-back results. Results are never dropped or overwritten while out_valid && !out_ready.
- Ties: equal values give that value; the choice of operand is irrelevant.
- Comparison is signed, DATA_W wide. No width growth; out_pix equals one of the 4 inputs bit-exactly.
- Throughput: (IMG_W/2)*(IMG_H/2) outputs per IMG_W*IMG_H inputs.
- frame_done: asserted the cycle after the output transfer of the window at row IMG_H-1, col IMG_W-1.
- Reset mid-frame: counters, out_valid and frame_done return to 0 immediately (async). A partially received frame is discarded; the next pixel is treated as row 0, col 0.
- in_valid low: all state holds; gaps may occur anywhere, including mid-window.

Optional Feature:
- Macro FUSED_RELU_EN.
- Defined: each accepted in_pix is clamped as in_pix[DATA_W-1] ? 0 : in_pix before pairing, so the standalone activation stage can be bypassed.
- Undefined: in_pix is used unmodified; negative values pool by signed max.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W constant.
  - pix_t typedef (signed logic [DATA_W-1:0]).
  - Function smax(pix_t a, pix_t b).
- Sub-module pool_line_buf: IMG_W/2-entry, single-write single-read register array.
  - Combinational read address col>>1; write enable on even-row odd-col transfer.
  - Suitable for distributed RAM inference.

Test Plan:
- 4x4 frame 1..16 raster, out_ready=1, no gaps -> outputs 6, 8, 14, 16 in order; out_valid 1 cycle after inputs 6, 8, 14, 16; frame_done pulses once after 16.
- 4x4 with window values {-5, -3, -7, -2} (no FUSED_RELU_EN) -> -2 (16'hFFFE). With FUSED_RELU_EN -> 0.
- Mixed 16'h7FFF and 16'h8000 in one window -> 16'h7FFF, confirming signed compare.
- out_ready held 0 for 10 cycles while streaming 1..16 -> in_ready drops after the first result; no result lost; order preserved after release.
- Random in_valid/out_ready (50%) over 3 back-to-back 28x28 frames vs reference model -> bit-exact 196 outputs per frame; frame_done count = 3.
- rst_n pulsed low after 9 pixels of a 4x4 frame, then full frame 1..16 -> only 6, 8, 14, 16 emitted; no stale line-buffer output.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel width, signed pixel type, signed max.
package cnn_pkg;
  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] pix_t;

  function automatic pix_t smax(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: holds the horizontal maxima of the even row.
// Async read, sync write, no reset; maps to distributed RAM.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool with valid/ready on both sides.
// Build option FUSED_RELU_EN clamps negative input pixels to zero.
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_pix,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);
  // Column counter keeps at least 2 bits so the buffer address is never 0-wide
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = $clog2(IMG_H);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_pair;
  pix_t          r_out;
  logic          r_out_valid;
  logic          r_last;
  logic          r_frame_done;

  pix_t          w_in;
  pix_t          w_h;
  pix_t          w_v;
  logic [DATA_W-1:0] w_lb;
  logic          w_acc;
  logic          w_col_odd;
  logic          w_row_odd;
  logic          w_end_col;
  logic          w_end_row;
  logic          w_lb_we;
  logic          w_load;

`ifdef FUSED_RELU_EN
  assign w_in = in_pix[DATA_W-1] ? '0 : pix_t'(in_pix);
`else
  assign w_in = pix_t'(in_pix);
`endif

  assign in_ready  = !r_out_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_col_odd = r_col[0];
  assign w_row_odd = r_row[0];
  assign w_end_col = (r_col == COL_LAST);
  assign w_end_row = (r_row == ROW_LAST);
  assign w_lb_we   = w_acc && w_col_odd && !w_row_odd;
  assign w_load    = w_acc && w_col_odd && w_row_odd;

  assign w_h = smax(r_pair, w_in);
  assign w_v = smax(pix_t'(w_lb), w_h);

  pool_line_buf #(
    .DEPTH (IMG_W / 2),
    .AW    (AW)
  ) u_lb (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_addr  (r_col[CW-1:1]),
    .i_wdata (w_h),
    .o_rdata (w_lb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_end_col) begin
        r_col <= '0;
        r_row <= w_end_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pair <= '0;
    else if (w_acc && !w_col_odd) r_pair <= w_in;
  end

  // A load in the same cycle as a drain wins, giving back-to-back results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_out       <= w_v;
        r_out_valid <= 1'b1;
        r_last      <= w_end_col && w_end_row;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_frame_done <= r_out_valid && out_ready && r_last;
    end
  end

  assign out_pix    = r_out;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: 4x4 directed frames and 28x28 random frames.
module tb_maxpool2x2_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_fd;
  logic [15:0] a_ip, a_op;
  logic        b_iv, b_ir, b_ov, b_or, b_fd;
  logic [15:0] b_ip, b_op;

  maxpool2x2_stream #(.IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_pix(a_ip), .in_valid(a_iv), .in_ready(a_ir),
    .out_pix(a_op), .out_valid(a_ov), .out_ready(a_or),
    .frame_done(a_fd)
  );

  maxpool2x2_stream #(.IMG_W(28), .IMG_H(28)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_pix(b_ip), .in_valid(b_iv), .in_ready(b_ir),
    .out_pix(b_op), .out_valid(b_ov), .out_ready(b_or),
    .frame_done(b_fd)
  );

  typedef struct {
    logic [15:0] v;
    bit          last;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] got_a[$];
  int          frm [2][784];
  int          kk [2];
  bit          fd_exp [2];
  bit          pend [2];
  logic [15:0] pend_v [2];
  int          nfd [2];
  int          nout [2];
  bit          saw_stall;
  bit          rnd_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] got(int i);
    return (i < got_a.size()) ? got_a[i] : 16'hDEAD;
  endfunction

  function automatic int relu(logic [15:0] p);
`ifdef FUSED_RELU_EN
    return p[15] ? 0 : int'($signed(p));
`else
    return int'($signed(p));
`endif
  endfunction

  // Model: store the frame, emit max of the 4 window pixels at bottom-right
  task automatic model_acc(int id, logic [15:0] p);
    int w, k, r, c, m;
    int idx [3];
    exp_t e;
    w = (id == 0) ? 4 : 28;
    k = kk[id];
    frm[id][k] = relu(p);
    r = k / w;
    c = k % w;
    if (r % 2 == 1 && c % 2 == 1) begin
      idx[0] = k - 1;
      idx[1] = k - w;
      idx[2] = k - w - 1;
      m = frm[id][k];
      for (int j = 0; j < 3; j++)
        if (frm[id][idx[j]] > m) m = frm[id][idx[j]];
      e.v = m[15:0];
      e.last = (k == w * w - 1);
      if (id == 0) qa.push_back(e);
      else qb.push_back(e);
      pend[id] = 1;
      pend_v[id] = e.v;
    end
    kk[id] = (k + 1) % (w * w);
  endtask

  task automatic mon(int id, logic iv, logic [15:0] ip, logic ir,
                     logic ov, logic [15:0] op, logic ordy, logic fd);
    exp_t e;
    string s;
    s = (id == 0) ? "a_" : "b_";
    if (!rst_n) begin
      check({s, "rst_ov"}, {31'd0, ov}, 0);
      check({s, "rst_fd"}, {31'd0, fd}, 0);
      check({s, "rst_op"}, {16'd0, op}, 0);
      kk[id] = 0;
      pend[id] = 0;
      fd_exp[id] = 0;
      if (id == 0) qa.delete();
      else qb.delete();
      return;
    end
    check({s, "in_ready"}, {31'd0, ir}, {31'd0, !ov || ordy});
    check({s, "frame_done"}, {31'd0, fd}, {31'd0, fd_exp[id]});
    fd_exp[id] = 0;
    if (fd) nfd[id]++;
    if (pend[id]) begin
      check({s, "lat_valid"}, {31'd0, ov}, 1);
      check({s, "lat_pix"}, {16'd0, op}, {16'd0, pend_v[id]});
      pend[id] = 0;
    end
    if (ov && ordy) begin
      if ((id == 0 ? qa.size() : qb.size()) == 0) begin
        check({s, "extra_out"}, {16'd0, op}, 32'hFFFF_FFFF);
      end else begin
        e = (id == 0) ? qa.pop_front() : qb.pop_front();
        check({s, "out_pix"}, {16'd0, op}, {16'd0, e.v});
        fd_exp[id] = e.last;
        nout[id]++;
        if (id == 0) got_a.push_back(op);
      end
    end
    if (id == 0 && !ir) saw_stall = 1;
    if (iv && ir) model_acc(id, ip);
  endtask

  always @(negedge clk) begin
    mon(0, a_iv, a_ip, a_ir, a_ov, a_op, a_or, a_fd);
    mon(1, b_iv, b_ip, b_ir, b_ov, b_op, b_or, b_fd);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_b) b_or = 1'($urandom_range(1));
    end
  end

  task automatic send_a(logic [15:0] p);
    int n;
    bit ok;
    a_ip = p;
    a_iv = 1;
    n = 0;
    do begin
      @(negedge clk);
      ok = a_ir;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("a_send_timeout", 0, 1);
    a_iv = 0;
  endtask

  task automatic send_b(logic [15:0] p);
    int n;
    bit ok;
    while ($urandom_range(1) == 0) begin
      b_iv = 0;
      @(posedge clk);
      #1;
    end
    b_ip = p;
    b_iv = 1;
    n = 0;
    do begin
      @(negedge clk);
      ok = b_ir;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("b_send_timeout", 0, 1);
    b_iv = 0;
  endtask

  task automatic run_a(logic [15:0] f [16]);
    got_a.delete();
    for (int i = 0; i < 16; i++) send_a(f[i]);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(string nm, logic [15:0] e0, logic [15:0] e1,
                         logic [15:0] e2, logic [15:0] e3);
    check({nm, "_cnt"}, got_a.size(), 4);
    check({nm, "_o0"}, {16'd0, got(0)}, {16'd0, e0});
    check({nm, "_o1"}, {16'd0, got(1)}, {16'd0, e1});
    check({nm, "_o2"}, {16'd0, got(2)}, {16'd0, e2});
    check({nm, "_o3"}, {16'd0, got(3)}, {16'd0, e3});
  endtask

  logic [15:0] f [16];
  int          n;

  initial begin
    rst_n = 0;
    a_iv = 0; a_ip = 0; a_or = 1;
    b_iv = 0; b_ip = 0; b_or = 1;
    rnd_b = 0;
    nfd = '{0, 0};
    nout = '{0, 0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 16; i++) f[i] = 16'(i + 1);
    run_a(f);
    chk_seq("t1", 16'd6, 16'd8, 16'd14, 16'd16);
    check("t1_fd_count", nfd[0], 1);

    for (int i = 0; i < 16; i++) f[i] = 16'd1;
    f[0] = 16'hFFFB; f[1] = 16'hFFFD;
    f[4] = 16'hFFF9; f[5] = 16'hFFFE;
    run_a(f);
`ifdef FUSED_RELU_EN
    chk_seq("t2", 16'h0000, 16'd1, 16'd1, 16'd1);
`else
    chk_seq("t2", 16'hFFFE, 16'd1, 16'd1, 16'd1);
`endif

    for (int i = 0; i < 16; i++) f[i] = 16'd0;
    f[0] = 16'h7FFF; f[1] = 16'h8000;
    f[4] = 16'h8000; f[5] = 16'h8000;
    run_a(f);
    chk_seq("t3", 16'h7FFF, 16'd0, 16'd0, 16'd0);

    for (int i = 0; i < 16; i++) f[i] = 16'(i + 1);
    a_or = 0;
    saw_stall = 0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 a_or = 1;
      end
    join_none
    run_a(f);
    chk_seq("t4", 16'd6, 16'd8, 16'd14, 16'd16);
    check("t4_stall_seen", {31'd0, saw_stall}, 1);

    got_a.delete();
    for (int i = 0; i < 9; i++) send_a(16'(i + 1));
    check("t5_pre_cnt", got_a.size(), 2);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    run_a(f);
    chk_seq("t5", 16'd6, 16'd8, 16'd14, 16'd16);
    check("a_drain", qa.size(), 0);

    nfd[1] = 0;
    nout[1] = 0;
    rnd_b = 1;
    for (int fr = 0; fr < 3; fr++)
      for (int i = 0; i < 784; i++) begin
        case ($urandom_range(7))
          0: send_b(16'h7FFF);
          1: send_b(16'h8000);
          default: send_b(16'($urandom));
        endcase
      end
    rnd_b = 0;
    b_or = 1;
    n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("b_out_count", nout[1], 588);
    check("b_fd_count", nfd[1], 3);
    check("b_drain", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
